// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Sequencer/arbiter for the single shared 32-bit memory port of the
//   multicycle RISC-V core. It serves instruction fetch (IF) and data
//   load/store (D), grants one requester at a time, and runs a fixed-latency
//   access (MEM_LAT cycles). When the access completes it returns read data
//   along with a one-cycle DONE pulse.
//
//   Parameter: MEM_LAT   memory read latency, 1..7 cycles
//   Macro:     ROUND_ROBIN_EN  when defined, contested requests alternate
//                              (a LAST register remembers the previous
//                              winner). When undefined, D has fixed
//                              priority over IF.
//
//   Ports:
//     CLK, RESET              clock (rising edge), async active-high reset
//     IF_REQ/IF_ADDR          fetch request (level) and address
//     IF_GNT/IF_DONE          fetch accepted / IF_RDATA valid (1-cycle pulses)
//     IF_RDATA                fetched word, held until the next IF_DONE
//     D_REQ/D_WE/D_ADDR/D_WDATA  data request, store flag, address, store data
//     D_GNT/D_DONE            data accepted / access complete (1-cycle pulses)
//     D_RDATA                 loaded word, unchanged by stores
//     MEM_ADDR/MEM_WDATA/MEM_WR  memory port, zero outside ACCESS
//     MEM_RDATA               memory read data, valid in last ACCESS cycle
//     BUSY                    high whenever not IDLE
//     OWNER                   current/last owner (0 = IF, 1 = D)
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_GNT,
    output logic        IF_DONE,
    output logic [31:0] IF_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_DONE,
    output logic [31:0] D_RDATA,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_WR,
    input  logic [31:0] MEM_RDATA,
    output logic        BUSY,
    output logic        OWNER
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q, wdata_q;
    logic        we_q, owner_q;
    logic        if_gnt_q, d_gnt_q, if_done_q, d_done_q;
    logic [31:0] if_rdata_q, d_rdata_q;

    logic req_any, win_d, last_cyc, grant;

    assign req_any  = IF_REQ | D_REQ;
    assign last_cyc = (cnt_q == 3'(MEM_LAT - 1));
    assign grant    = (state_q == IDLE) && req_any;

`ifdef ROUND_ROBIN_EN
    // LAST: previous winner (1 = D). On contention the other port wins.
    logic last_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)      last_q <= 1'b1;
        else if (grant) last_q <= win_d;
    end
    assign win_d = (IF_REQ && D_REQ) ? ~last_q : D_REQ;
`else
    assign win_d = D_REQ;
`endif

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any)  state_d = ACCESS;
            ACCESS:  if (last_cyc) state_d = RESP;
            RESP:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Request latches, latency counter, registered GNT/DONE and read data
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_q    <= 1'b0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_gnt_q  <= grant && !win_d;
            d_gnt_q   <= grant &&  win_d;
            if_done_q <= (state_q == ACCESS) && last_cyc && !owner_q;
            d_done_q  <= (state_q == ACCESS) && last_cyc &&  owner_q;
            if (grant) begin
                owner_q <= win_d;
                addr_q  <= win_d ? D_ADDR  : IF_ADDR;
                wdata_q <= win_d ? D_WDATA : 32'h0;   // fetches never write
                we_q    <= win_d & D_WE;
                cnt_q   <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 3'd1;
                if (last_cyc && !we_q) begin
                    if (owner_q) d_rdata_q  <= MEM_RDATA;
                    else         if_rdata_q <= MEM_RDATA;
                end
            end
        end
    end

    // Outputs. The GNT flop marks the first ACCESS cycle, which is the only
    // cycle carrying the write strobe.
    always_comb begin
        MEM_ADDR  = 32'h0;
        MEM_WDATA = 32'h0;
        MEM_WR    = 1'b0;
        if (state_q == ACCESS) begin
            MEM_ADDR  = addr_q;
            MEM_WDATA = wdata_q;
            MEM_WR    = we_q && (if_gnt_q || d_gnt_q);
        end
        BUSY     = (state_q != IDLE);
        OWNER    = owner_q;
        IF_GNT   = if_gnt_q;
        D_GNT    = d_gnt_q;
        IF_DONE  = if_done_q;
        D_DONE   = d_done_q;
        IF_RDATA = if_rdata_q;
        D_RDATA  = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timeline reference model (cycles since
// grant) checked every cycle against a MEM_LAT=2 instance, plus a MEM_LAT=1
// instance for the short-latency load case. Handles ROUND_ROBIN_EN.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        IF_REQ = 0, D_REQ = 0, D_WE = 0;
    logic [31:0] IF_ADDR = 0, D_ADDR = 0, D_WDATA = 0;

    logic        if_gnt0, if_done0, d_gnt0, d_done0, mwr0, busy0, owner0;
    logic [31:0] if_rd0, d_rd0, maddr0, mwd0, rd0;
    logic        if_gnt1, if_done1, d_gnt1, d_done1, mwr1, busy1, owner1;
    logic [31:0] if_rd1, d_rd1, maddr1, mwd1, rd1;

    bit          ovr = 0;
    logic [31:0] ovr_val = 0;

    int vectors = 0, miscompares = 0;

    // Reference model state
    int          t;          // 0 idle, 1..LAT access, LAT+1 done cycle
    bit          m_owner, m_we, m_last;
    logic [31:0] m_addr, m_wd, m_ifrd, m_drd;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign rd0 = ovr ? ovr_val : hashf(maddr0);
    assign rd1 = ovr ? ovr_val : hashf(maddr1);

    mem_arbiter #(.MEM_LAT(LAT)) u0 (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(if_gnt0), .IF_DONE(if_done0), .IF_RDATA(if_rd0),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(d_gnt0), .D_DONE(d_done0), .D_RDATA(d_rd0),
        .MEM_ADDR(maddr0), .MEM_WDATA(mwd0), .MEM_WR(mwr0), .MEM_RDATA(rd0),
        .BUSY(busy0), .OWNER(owner0));

    mem_arbiter #(.MEM_LAT(1)) u1 (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(if_gnt1), .IF_DONE(if_done1), .IF_RDATA(if_rd1),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(d_gnt1), .D_DONE(d_done1), .D_RDATA(d_rd1),
        .MEM_ADDR(maddr1), .MEM_WDATA(mwd1), .MEM_WR(mwr1), .MEM_RDATA(rd1),
        .BUSY(busy1), .OWNER(owner1));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_owner = 0; m_we = 0; m_last = 1;
        m_addr = 0; m_wd = 0; m_ifrd = 0; m_drd = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit w;
        if (t == 0) begin
            if (IF_REQ || D_REQ) begin
`ifdef ROUND_ROBIN_EN
                w = (IF_REQ && D_REQ) ? ~m_last : D_REQ;
                m_last = w;
`else
                w = D_REQ;
`endif
                m_owner = w;
                m_addr  = w ? D_ADDR : IF_ADDR;
                m_wd    = w ? D_WDATA : 32'h0;
                m_we    = w && D_WE;
                t = 1;
            end
        end else if (t == LAT + 1) begin
            t = 0;
        end else begin
            if (t == LAT && !m_we) begin
                if (m_owner) m_drd  = ovr ? ovr_val : hashf(m_addr);
                else         m_ifrd = ovr ? ovr_val : hashf(m_addr);
            end
            t++;
        end
    endtask

    task automatic check_all();
        bit acc;
        acc = (t >= 1) && (t <= LAT);
        chk1 ("IF_GNT",    if_gnt0,  t == 1 && !m_owner);
        chk1 ("D_GNT",     d_gnt0,   t == 1 &&  m_owner);
        chk1 ("IF_DONE",   if_done0, t == LAT + 1 && !m_owner);
        chk1 ("D_DONE",    d_done0,  t == LAT + 1 &&  m_owner);
        chk1 ("BUSY",      busy0,    t != 0);
        chk1 ("OWNER",     owner0,   m_owner);
        chk1 ("MEM_WR",    mwr0,     t == 1 && m_we);
        chk32("MEM_ADDR",  maddr0,   acc ? m_addr : 32'h0);
        chk32("MEM_WDATA", mwd0,     acc ? m_wd   : 32'h0);
        chk32("IF_RDATA",  if_rd0,   m_ifrd);
        chk32("D_RDATA",   d_rd0,    m_drd);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    task automatic auto_drop();
        if (IF_REQ && if_gnt0) IF_REQ = 0;
        if (D_REQ && d_gnt0)   D_REQ = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        check_all();                               // reset state
        RESET = 0;

        // Fetch from 0x4, memory returns an ADDI encoding
        ovr = 1; ovr_val = 32'h00100093;
        IF_REQ = 1; IF_ADDR = 32'h4;
        step(); chk1("T1 IF_GNT c1", if_gnt0, 1'b1); chk1("T1 BUSY c1", busy0, 1'b1);
        IF_REQ = 0;
        step(); chk1("T1 BUSY c2", busy0, 1'b1);
        step(); chk1("T1 IF_DONE c3", if_done0, 1'b1);
        chk32("T1 IF_RDATA", if_rd0, 32'h00100093);
        step(); chk1("T1 BUSY c4", busy0, 1'b0);

        // Store 0xDEADBEEF to 0x40
        D_REQ = 1; D_WE = 1; D_ADDR = 32'h40; D_WDATA = 32'hDEADBEEF;
        step(); chk1("T2 MEM_WR c1", mwr0, 1'b1);
        chk32("T2 MEM_ADDR", maddr0, 32'h40); chk32("T2 MEM_WDATA", mwd0, 32'hDEADBEEF);
        D_REQ = 0;
        step(); chk1("T2 MEM_WR c2", mwr0, 1'b0);
        step(); chk1("T2 D_DONE c3", d_done0, 1'b1); chk32("T2 D_RDATA", d_rd0, 32'h0);
        step();

        // Contested requests
        ovr = 0; D_WE = 0;
        IF_REQ = 1; IF_ADDR = 32'h100; D_REQ = 1; D_ADDR = 32'h200;
        step();
`ifdef ROUND_ROBIN_EN
        chk1("T3 IF_GNT c1", if_gnt0, 1'b1); chk1("T3 OWNER c1", owner0, 1'b0);
        IF_REQ = 0;
        step(); step(); step();
        IF_REQ = 1;                                // contested again at end of c4
        step(); chk1("T3 D_GNT c5", d_gnt0, 1'b1); chk1("T3 OWNER c5", owner0, 1'b1);
        D_REQ = 0;
        step(); step(); chk1("T3 D_DONE c7", d_done0, 1'b1);
`else
        chk1("T3 D_GNT c1", d_gnt0, 1'b1); chk1("T3 OWNER c1", owner0, 1'b1);
        D_REQ = 0;
        step(); step(); chk1("T3 D_DONE c3", d_done0, 1'b1);
        step();
        step(); chk1("T3 IF_GNT c5", if_gnt0, 1'b1); chk1("T3 OWNER c5", owner0, 1'b0);
        IF_REQ = 0;
        step(); step(); chk1("T3 IF_DONE c7", if_done0, 1'b1);
`endif
        repeat (8) begin auto_drop(); step(); end

        // Reset in cycle 2 of a store
        D_REQ = 1; D_WE = 1; D_ADDR = 32'h44; D_WDATA = 32'h0BADF00D;
        step(); D_REQ = 0;
        step();
        RESET = 1; #1;
        model_reset();
        check_all();
        chk1("T5 MEM_WR in reset", mwr0, 1'b0); chk1("T5 BUSY in reset", busy0, 1'b0);
        @(negedge CLK); check_all();
        RESET = 0;
        D_WE = 0; IF_REQ = 1; IF_ADDR = 32'h8;
        step(); IF_REQ = 0;
        step(); step(); chk1("T5 IF_DONE after reset", if_done0, 1'b1);
        step(); step();

        // MEM_LAT=1 load on the second instance
        ovr = 1; ovr_val = 32'h12345678;
        D_REQ = 1; D_WE = 0; D_ADDR = 32'h80;
        step(); chk1("T6 L1 D_GNT c1", d_gnt1, 1'b1);
        D_REQ = 0;
        step(); chk1("T6 L1 D_DONE c2", d_done1, 1'b1);
        chk32("T6 L1 D_RDATA", d_rd1, 32'h12345678);
        step(); step();
        ovr = 0;

        // Random traffic obeying the requester rule
        for (int i = 0; i < 400; i++) begin
            auto_drop();
            if (!IF_REQ && $urandom_range(2) == 0) begin
                IF_REQ = 1; IF_ADDR = $urandom;
            end
            if (!D_REQ && $urandom_range(2) == 0) begin
                D_REQ = 1; D_WE = $urandom_range(1) == 1;
                D_ADDR = $urandom; D_WDATA = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single shared 32-bit memory port of the multicycle RISC-V core. It serves two requesters: instruction fetch (IF) from the control unit's fetch state, and data load/store (D) from the LD/SD states. It grants one requester at a time, drives the memory address, write data and write strobe for a fixed-latency access, and returns read data with a one-cycle DONE pulse.

## Interface
- MEM_LAT, 2: memory read latency in cycles, legal range 1..7.
- CLK  in  1  clock, rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- IF_REQ  in  1  fetch request, level; held until IF_GNT.
- IF_ADDR  in  32  fetch address.
- IF_GNT  out  1  one-cycle pulse: fetch accepted.
- IF_DONE  out  1  one-cycle pulse: IF_RDATA valid.
- IF_RDATA  out  32  fetched word; held until the next IF_DONE.
- D_REQ  in  1  data request, level; held until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_GNT  out  1  one-cycle pulse: data request accepted.
- D_DONE  out  1  one-cycle pulse: access complete; D_RDATA valid for a load.
- D_RDATA  out  32  loaded word; unchanged by stores.
- MEM_ADDR  out  32  memory address.
- MEM_WDATA  out  32  memory write data.
- MEM_WR  out  1  memory write strobe: 1 = write, 0 = read.
- MEM_RDATA  in  32  memory read data.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  current or last owner: 0 = IF, 1 = D.

## Operation
- States: IDLE, ACCESS, RESP. A 3-bit counter CNT runs inside ACCESS.
- **IDLE**
  - If either REQ is high at the clock edge: pick a winner, latch its address, write data and WE (WE is 0 for IF), set OWNER, clear CNT, go to ACCESS.
  - Otherwise stay in IDLE.
  - REQ is ignored in every state other than IDLE.
- **ACCESS**
  - Lasts exactly MEM_LAT cycles.
  - The winner's GNT is high in the first ACCESS cycle only.
  - MEM_ADDR and MEM_WDATA are driven from the latches for all ACCESS cycles.
  - MEM_WR equals the latched WE in the first ACCESS cycle only.
  - CNT increments each cycle. When CNT = MEM_LAT−1, the edge captures MEM_RDATA into the owner's RDATA register (loads and fetches only) and moves to RESP.
- **RESP**
  - The owner's DONE is high for one cycle; then go to IDLE.
- Requester rule: drop REQ in the cycle after GNT. A REQ still high in IDLE starts a new access.
- Arbitration without the macro: D has fixed priority over IF when both are high.
- Outside ACCESS, MEM_ADDR, MEM_WDATA and MEM_WR are 0.
- Addresses pass through unchecked; there is no alignment check.

## Timing
- Reset values:
  - state IDLE; CNT 0; OWNER 0.
  - all GNT and DONE outputs 0; MEM_WR, MEM_ADDR, MEM_WDATA 0.
  - IF_RDATA and D_RDATA 0; BUSY 0.
- Reset mid-operation:
  - the access is aborted immediately (asynchronous); MEM_WR drops with RESET.
  - no DONE is issued; the aborted requester must re-request.
- REQ sampled at the edge ending cycle 0:
  - GNT in cycle 1; ACCESS covers cycles 1..MEM_LAT.
  - DONE in cycle MEM_LAT+1; IDLE in cycle MEM_LAT+2.
- Minimum spacing between grants is MEM_LAT+2 cycles; there are no back-to-back grants.
- MEM_RDATA must be valid in the last ACCESS cycle.
- GNT and DONE are registered outputs. DONE is never high together with any GNT.

## Configuration
- ROUND_ROBIN_EN defined:
  - a priority bit LAST (reset 1 = D) is updated on every grant to the granted port.
  - when both REQ are high, the port other than LAST wins, so the first contested grant goes to IF.
- ROUND_ROBIN_EN undefined: fixed D-over-IF priority; the LAST register is not built.

## Test plan
- IF_REQ with IF_ADDR=0x00000004, MEM_LAT=2, memory returns 0x00100093 → IF_GNT in cycle 1, IF_DONE in cycle 3, IF_RDATA=0x00100093, BUSY high in cycles 1–3.
- D_REQ with D_WE=1, D_ADDR=0x40, D_WDATA=0xDEADBEEF → MEM_WR high in cycle 1 only, MEM_ADDR=0x40, MEM_WDATA=0xDEADBEEF, D_DONE in cycle 3, D_RDATA unchanged.
- IF_REQ and D_REQ both high in cycle 0, macro off → D_GNT in cycle 1, D_DONE in cycle 3, IF_GNT in cycle 5, IF_DONE in cycle 7, OWNER=1 then 0.
- ROUND_ROBIN_EN, two successive contested requests → first grant to IF, second grant to D.
- RESET asserted in cycle 2 of a D store → all outputs 0 immediately, no D_DONE; a new IF_REQ after reset completes normally (IF_DONE 3 cycles after sampling).
- MEM_LAT=1 load from 0x80, memory returns 0x12345678 → D_GNT in cycle 1, D_DONE in cycle 2, D_RDATA=0x12345678.
